// File: rtl/alu_result_stage.sv
// Execute-to-writeback pipeline register behind the miniRISC ALU: result/carry capture,
// branch resolution against the architectural carry flag, writeback controls and retire count.
module alu_result_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_carry,
    input  logic              in_carry_we,
    input  logic              in_we,
    input  logic [REG_AW-1:0] in_dest,
    input  logic [2:0]        in_br_type,
    input  logic [DATA_W-1:0] in_src,
    input  logic [DATA_W-1:0] in_br_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              br_taken,
    output logic [DATA_W-1:0] br_target,
    output logic              carry_flag,
    output logic [31:0]       retired
);

    // Handshake: a transfer happens on a port when valid && ready are both high at the
    // rising edge; valid never depends on ready, and flush suppresses both transfers.
    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_ALW  = 3'b001;
    localparam logic [2:0] BR_LTZ  = 3'b010;
    localparam logic [2:0] BR_Z    = 3'b011;
    localparam logic [2:0] BR_NZ   = 3'b100;
    localparam logic [2:0] BR_CY   = 3'b101;
    localparam logic [2:0] BR_NCY  = 3'b110;

    logic accept;
    logic out_fire;
    logic branch_cond;
    logic dest_nonzero;

    assign in_ready     = !flush && (!out_valid || out_ready);
    assign accept       = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready && !flush;
    assign dest_nonzero = (in_dest != '0);

    // Conditions read the flag as it stands before this instruction's own carry update.
    always_comb begin
        branch_cond = 1'b0;
        case (in_br_type)
            BR_NONE: branch_cond = 1'b0;
            BR_ALW:  branch_cond = 1'b1;
            BR_LTZ:  branch_cond = in_src[DATA_W-1];
            BR_Z:    branch_cond = (in_src == '0);
            BR_NZ:   branch_cond = (in_src != '0);
            BR_CY:   branch_cond = carry_flag;
            BR_NCY:  branch_cond = !carry_flag;
            default: branch_cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            br_taken  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            br_taken  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            br_taken  <= branch_cond;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            br_target <= '0;
        end else if (accept) begin
            wb_en     <= in_we && dest_nonzero;
            wb_addr   <= in_dest;
            wb_data   <= in_result;
            br_target <= in_br_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_flag <= 1'b0;
        end else if (accept && in_carry_we) begin
            carry_flag <= in_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (out_fire) begin
            retired <= retired + 32'd1;
        end
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-writeback pipeline register directly downstream of the miniRISC ALU.
- Captures the ALU result and carry with a valid/ready handshake, and maintains the architectural carry flag.
- Evaluates the branch condition for bcy, bncy, bz, bnz, bltz and unconditional branches.
- Presents register-file write controls and branch redirect to the writeback/fetch logic, and counts retired instructions.

Parameters:
DATA_W, 32, datapath width of ALU result, source operand and branch target
REG_AW, 5, register address width (32 registers, register 0 hardwired zero)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline kill from fetch redirect
in_valid  input  1  upstream ALU stage holds a valid instruction
in_ready  output  1  stage can accept this cycle
in_result  input  DATA_W  ALU result
in_carry  input  1  ALU carry out
in_carry_we  input  1  instruction updates carry flag
in_we  input  1  instruction writes a register
in_dest  input  REG_AW  destination register
in_br_type  input  3  branch kind (encoding below)
in_src  input  DATA_W  register value tested by bz/bnz/bltz
in_br_target  input  DATA_W  computed branch target
out_valid  output  1  output register holds an instruction
out_ready  input  1  downstream accepts
wb_en  output  1  register-file write enable (qualified)
wb_addr  output  REG_AW  write address
wb_data  output  DATA_W  write data
br_taken  output  1  redirect request (qualified by out_valid)
br_target  output  DATA_W  redirect address
carry_flag  output  1  architectural carry flag
retired  output  32  retired-instruction counter

Behaviour:
- Reset (async, rst_n=0): out_valid=0, wb_en=0, wb_addr=0, wb_data=0, br_taken=0, br_target=0, carry_flag=0, retired=0. Release is synchronous to clk; the first acceptance is possible on the first edge after release.
- in_ready = !flush && (!out_valid || out_ready). This is combinational and gives full throughput (one instruction per cycle) with no bubbles.
- Accept on in_valid && in_ready. At that edge, all out_* and wb_* fields load from inputs and out_valid becomes 1. Latency is 1 cycle.
- out_valid && out_ready && !accept: out_valid becomes 0. Other data fields hold their values.
- wb_en = in_we && (in_dest != 0), registered. A write to register 0 is always suppressed. wb_en is meaningful only while out_valid=1.
- Carry flag:
  - Updates to in_carry on accept when in_carry_we=1. Otherwise it holds.
  - Branch evaluation uses carry_flag before that update. An instruction's own carry never affects its own branch decision.
- br_type encoding and condition for the registered br_taken:
  - 000 none → 0
  - 001 br → 1
  - 010 bltz → in_src[DATA_W-1]
  - 011 bz → in_src==0
  - 100 bnz → in_src!=0
  - 101 bcy → carry_flag
  - 110 bncy → !carry_flag
  - 111 reserved → 0
- br_target is registered from in_br_target regardless of taken.
- retired increments by 1 on each output handshake (out_valid && out_ready). It wraps from 0xFFFFFFFF to 0.
- Flush has priority over everything:
  - At the edge, out_valid becomes 0 and br_taken becomes 0.
  - No acceptance occurs that cycle (in_ready=0), and carry_flag is not updated.
  - retired does not count a flushed entry, even if out_ready=1 in the same cycle.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable and carry_flag holds.
- Reset mid-operation: all state clears immediately without waiting for a clock edge, and any in-flight entry is lost.

Test Plan:
1. Single accept of in_result=0x0000000A, in_we=1, in_dest=3, out_ready=1 → one cycle later out_valid=1, wb_en=1, wb_addr=3, wb_data=0x0A. retired=1 after the handshake.
2. Back-to-back accept of adds 3+7=10 (carry 0), then 0xFFFFFFFF+1=0 (in_carry=1, in_carry_we=1) → carry_flag=1 after the second edge. in_ready stays 1 throughout, with no bubble.
3. carry_flag=1, then bcy with in_carry_we=1, in_carry=0 → br_taken=1 (uses old flag). carry_flag becomes 0, and a following bncy is taken.
4. bz with in_src=0 → taken. bnz with in_src=0 → not taken. bltz with in_src=0x80000000 → taken. br_type=111 → not taken. br_target always equals the input target.
5. out_ready=0 for 3 cycles with out_valid=1 → in_ready=0 and outputs frozen. The in_valid instruction is accepted on the cycle out_ready returns to 1.
6. flush asserted with in_valid=1 and out_valid=1 → next cycle out_valid=0, carry_flag unchanged, retired unchanged. Separately, in_dest=0 with in_we=1 gives wb_en=0, and async rst_n low mid-stall clears all outputs immediately.
